// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency single-port memory
// between the instruction-fetch port (read-only) and the load/store port.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_enable,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_d_q, last_d_d;
   logic              sel_d_q, sel_d_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic              en_q, en_d, mwr_q, mwr_d;
   logic              i_valid_q, i_valid_d, d_valid_q, d_valid_d;
   logic              busy_q, busy_d;
   logic              pick_i, pick_d;
   // last_d_q=1 means the D side was served last, so I wins the next tie
   always_comb begin
      pick_i    = (state_q == IDLE) && rst_n && i_req && (!d_req || last_d_q);
      pick_d    = (state_q == IDLE) && rst_n && d_req && (!i_req || !last_d_q);
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d_d  = last_d_q;
      sel_d_d   = sel_d_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (pick_i || pick_d) begin
               state_d  = ACCESS;
               cnt_d    = 4'(LATENCY - 1);
               last_d_d = pick_d;
               sel_d_d  = pick_d;
               addr_d   = pick_d ? d_addr : i_addr;
               wr_d     = pick_d && d_wr;
               wdata_d  = pick_d ? d_wdata : wdata_q;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d   = RESP;
               i_rdata_d = !sel_d_q ? mem_rdata : i_rdata_q;
               d_rdata_d = (sel_d_q && !wr_q) ? mem_rdata : d_rdata_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      en_d      = state_d == ACCESS;
      mwr_d     = (state_d == ACCESS) && wr_d;
      i_valid_d = (state_d == RESP) && !sel_d_d;
      d_valid_d = (state_d == RESP) && sel_d_d;
      busy_d    = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_d_q  <= 1'b1;
         sel_d_q   <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         en_q      <= 1'b0;
         mwr_q     <= 1'b0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_d_q  <= last_d_d;
         sel_d_q   <= sel_d_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         en_q      <= en_d;
         mwr_q     <= mwr_d;
         i_valid_q <= i_valid_d;
         d_valid_q <= d_valid_d;
         busy_q    <= busy_d;
      end
   end
   assign i_gnt      = pick_i;
   assign d_gnt      = pick_d;
   assign i_valid    = i_valid_q;
   assign d_valid    = d_valid_q;
   assign i_rdata    = i_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_enable = en_q;
   assign mem_wr     = mwr_q;
   assign busy       = busy_q;
endmodule
